// File: rtl/adder_nbits_pipeline_sel_pkg.sv
// adder_pkg: mode-selection constants shared by the adder_nbits_pipeline_sel slice.
// Rev 1.0
`default_nettype none

package adder_pkg;

  localparam int HIGH_SPEED_MHZ = 150;

  function automatic bit is_high_mode(input int freq);
    return freq > HIGH_SPEED_MHZ;
  endfunction

endpackage

`default_nettype wire

// File: rtl/adder_nbits_pipeline_sel_seg_stage.sv
// adder_seg_stage: SEG-bit registered segment adder with carry in/out and enable.
// Rev 1.0
`default_nettype none

module adder_seg_stage #(
  parameter int SEG = 4
) (
  input  logic           clk_i,
  input  logic           rst_ni,
  input  logic           en_i,
  input  logic [SEG-1:0] a_i,
  input  logic [SEG-1:0] b_i,
  input  logic           cin_i,
  output logic [SEG-1:0] sum_o,
  output logic           cout_o
);

  logic [SEG:0]   sum_d;
  logic [SEG-1:0] sum_q;
  logic           cout_q;

  always_comb begin
    sum_d = {1'b0, a_i} + {1'b0, b_i} + {{SEG{1'b0}}, cin_i};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else if (en_i) begin
      sum_q  <= sum_d[SEG-1:0];
      cout_q <= sum_d[SEG];
    end
  end

  assign sum_o  = sum_q;
  assign cout_o = cout_q;

endmodule

`default_nettype wire

// File: rtl/adder_nbits_pipeline_sel.sv
// adder_nbits_pipeline_sel: valid/ready N-bit adder, single register below HIGH_SPEED_MHZ,
// carry-segmented STAGES-deep pipeline above it. Define ADDER_OVF_EN for the ovf output. Rev 1.0
`default_nettype none

module adder_nbits_pipeline_sel
  import adder_pkg::*;
#(
  parameter int WIDTH           = 16,
  parameter int STAGES          = 4,
  parameter int CLOCK_FREQUENCY = 100
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam bit HIGH_MODE = is_high_mode(CLOCK_FREQUENCY);
  localparam int DEPTH     = HIGH_MODE ? STAGES : 1;
  localparam int SEG       = WIDTH / DEPTH;

  logic             en;
  logic             accept;
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [SEG-1:0]   seg_sum [DEPTH];
  logic             seg_carry [DEPTH];
  logic [SEG-1:0]   out_seg [DEPTH];

  // A single global enable freezes every stage, so bubbles keep their slots while stalled.
  assign en        = ~out_valid | out_ready;
  assign in_ready  = en;
  assign accept    = in_valid & en;
  assign out_valid = valid_q[DEPTH-1];

  always_comb begin
    valid_d    = valid_q;
    valid_d[0] = accept;
    for (int k = 1; k < DEPTH; k++) begin
      valid_d[k] = valid_q[k-1];
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      valid_q <= '0;
    end else if (en) begin
      valid_q <= valid_d;
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    localparam int ALIGN = DEPTH - 1 - k;

    logic [SEG-1:0] a_seg;
    logic [SEG-1:0] b_seg;
    logic           stage_cin;

    if (k == 0) begin : g_first
      assign a_seg     = a[SEG-1:0];
      assign b_seg     = b[SEG-1:0];
      assign stage_cin = cin;
    end else begin : g_skew
      // Segment k waits k cycles so it meets the carry produced for the same operand.
      logic [SEG-1:0] a_sk_q [k];
      logic [SEG-1:0] b_sk_q [k];

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int i = 0; i < k; i++) begin
            a_sk_q[i] <= '0;
            b_sk_q[i] <= '0;
          end
        end else if (en) begin
          a_sk_q[0] <= a[k*SEG +: SEG];
          b_sk_q[0] <= b[k*SEG +: SEG];
          for (int i = 1; i < k; i++) begin
            a_sk_q[i] <= a_sk_q[i-1];
            b_sk_q[i] <= b_sk_q[i-1];
          end
        end
      end

      assign a_seg     = a_sk_q[k-1];
      assign b_seg     = b_sk_q[k-1];
      assign stage_cin = seg_carry[k-1];
    end

    adder_seg_stage #(
      .SEG (SEG)
    ) u_stage (
      .clk_i  (CLK),
      .rst_ni (RST),
      .en_i   (en),
      .a_i    (a_seg),
      .b_i    (b_seg),
      .cin_i  (stage_cin),
      .sum_o  (seg_sum[k]),
      .cout_o (seg_carry[k])
    );

    if (ALIGN == 0) begin : g_no_align
      assign out_seg[k] = seg_sum[k];
    end else begin : g_align
      // Finished low segments wait for the upper segments of the same operand.
      logic [SEG-1:0] al_q [ALIGN];

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          for (int i = 0; i < ALIGN; i++) begin
            al_q[i] <= '0;
          end
        end else if (en) begin
          al_q[0] <= seg_sum[k];
          for (int i = 1; i < ALIGN; i++) begin
            al_q[i] <= al_q[i-1];
          end
        end
      end

      assign out_seg[k] = al_q[ALIGN-1];
    end
  end

  always_comb begin
    sum = '0;
    for (int k = 0; k < DEPTH; k++) begin
      sum[k*SEG +: SEG] = out_seg[k];
    end
  end

  assign c = seg_carry[DEPTH-1];

`ifdef ADDER_OVF_EN
  logic [DEPTH-1:0] a_msb_q;
  logic [DEPTH-1:0] b_msb_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      a_msb_q <= '0;
      b_msb_q <= '0;
    end else if (en) begin
      a_msb_q[0] <= a[WIDTH-1];
      b_msb_q[0] <= b[WIDTH-1];
      for (int k = 1; k < DEPTH; k++) begin
        a_msb_q[k] <= a_msb_q[k-1];
        b_msb_q[k] <= b_msb_q[k-1];
      end
    end
  end

  assign ovf = (a_msb_q[DEPTH-1] == b_msb_q[DEPTH-1]) & (sum[WIDTH-1] != a_msb_q[DEPTH-1]);
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder_nbits_pipeline_sel.sv
// tb_adder_nbits_pipeline_sel: checks a 4-stage (200 MHz) and a single-register (50 MHz) 8-bit adder.
// Rev 1.0
`default_nettype none

module tb_adder_nbits_pipeline_sel;

  localparam int W  = 8;
  localparam int HD = 4;

  typedef struct packed {
    logic         v;
    logic [W-1:0] s;
    logic         c;
    logic         o;
  } ent_t;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic         RST;
  logic         hv, hr, hcin, hov, hordy, hc;
  logic [W-1:0] ha, hb, hs;
  logic         lv, lr, lcin, lov, lordy, lc;
  logic [W-1:0] la, lb, ls;
`ifdef ADDER_OVF_EN
  logic         hovf, lovf;
`endif

  int checks = 0;
  int errors = 0;

  ent_t mh [HD];
  ent_t ml;

  adder_nbits_pipeline_sel #(.WIDTH(W), .STAGES(HD), .CLOCK_FREQUENCY(200)) u_hi (
    .CLK(CLK), .RST(RST), .in_valid(hv), .in_ready(hr), .a(ha), .b(hb), .cin(hcin),
    .out_valid(hov), .out_ready(hordy), .sum(hs), .c(hc)
`ifdef ADDER_OVF_EN
    , .ovf(hovf)
`endif
  );

  adder_nbits_pipeline_sel #(.WIDTH(W), .STAGES(HD), .CLOCK_FREQUENCY(50)) u_lo (
    .CLK(CLK), .RST(RST), .in_valid(lv), .in_ready(lr), .a(la), .b(lb), .cin(lcin),
    .out_valid(lov), .out_ready(lordy), .sum(ls), .c(lc)
`ifdef ADDER_OVF_EN
    , .ovf(lovf)
`endif
  );

  function automatic ent_t ref_add(input logic v, input logic [W-1:0] x, input logic [W-1:0] y,
                                   input logic ci);
    int   t;
    ent_t e;
    t   = int'(x) + int'(y) + int'(ci);
    e.v = v;
    e.s = t[W-1:0];
    e.c = t[W];
    e.o = (x[W-1] == y[W-1]) && (t[W-1] != x[W-1]);
    return e;
  endfunction

  task automatic clear_models();
    for (int i = 0; i < HD; i++) mh[i] = '0;
    ml = '0;
  endtask

  task automatic idle_inputs();
    hv = 1'b0; ha = '0; hb = '0; hcin = 1'b0; hordy = 1'b1;
    lv = 1'b0; la = '0; lb = '0; lcin = 1'b0; lordy = 1'b1;
  endtask

  // Entered just after a falling edge with inputs already driven; returns at the next falling edge.
  task automatic tick();
    ent_t eh, el;
    logic erh, erl;
    #1;
    eh  = mh[HD-1];
    el  = ml;
    erh = !eh.v || hordy;
    erl = !el.v || lordy;
    checks++;
    if (hov !== eh.v) begin
      errors++; $display("FAIL hi_out_valid t=%0t got %b expected %b", $time, hov, eh.v);
    end
    checks++;
    if (hr !== erh) begin
      errors++; $display("FAIL hi_in_ready t=%0t got %b expected %b", $time, hr, erh);
    end
    if (eh.v) begin
      checks++;
      if ({hc, hs} !== {eh.c, eh.s}) begin
        errors++; $display("FAIL hi_sum t=%0t got c=%b sum=%h expected c=%b sum=%h",
                           $time, hc, hs, eh.c, eh.s);
      end
`ifdef ADDER_OVF_EN
      checks++;
      if (hovf !== eh.o) begin
        errors++; $display("FAIL hi_ovf t=%0t got %b expected %b", $time, hovf, eh.o);
      end
`endif
    end
    checks++;
    if (lov !== el.v) begin
      errors++; $display("FAIL lo_out_valid t=%0t got %b expected %b", $time, lov, el.v);
    end
    checks++;
    if (lr !== erl) begin
      errors++; $display("FAIL lo_in_ready t=%0t got %b expected %b", $time, lr, erl);
    end
    if (el.v) begin
      checks++;
      if ({lc, ls} !== {el.c, el.s}) begin
        errors++; $display("FAIL lo_sum t=%0t got c=%b sum=%h expected c=%b sum=%h",
                           $time, lc, ls, el.c, el.s);
      end
`ifdef ADDER_OVF_EN
      checks++;
      if (lovf !== el.o) begin
        errors++; $display("FAIL lo_ovf t=%0t got %b expected %b", $time, lovf, el.o);
      end
`endif
    end
    @(posedge CLK);
    if (erh) begin
      for (int i = HD - 1; i > 0; i--) mh[i] = mh[i-1];
      mh[0] = ref_add(hv, ha, hb, hcin);
    end
    if (erl) ml = ref_add(lv, la, lb, lcin);
    @(negedge CLK);
  endtask

  task automatic check_reset_outputs(input int tag);
    checks++;
    if ({hov, lov} !== 2'b00) begin
      errors++; $display("FAIL reset_out_valid[%0d] got hi=%b lo=%b expected 0", tag, hov, lov);
    end
    checks++;
    if ({hc, hs, lc, ls} !== '0) begin
      errors++; $display("FAIL reset_data[%0d] got hi=%b/%h lo=%b/%h expected 0", tag, hc, hs, lc, ls);
    end
`ifdef ADDER_OVF_EN
    checks++;
    if ({hovf, lovf} !== 2'b00) begin
      errors++; $display("FAIL reset_ovf[%0d] got hi=%b lo=%b expected 0", tag, hovf, lovf);
    end
`endif
  endtask

  task automatic test_reset();
    RST = 1'b0;
    idle_inputs();
    clear_models();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    #1;
    check_reset_outputs(0);
    RST = 1'b1;
    @(negedge CLK);
    repeat (2) tick();
  endtask

  task automatic test_carry_ripple();
    hv = 1'b1; ha = 8'hFF; hb = 8'h01; hcin = 1'b0;
    tick();
    idle_inputs();
    repeat (HD + 2) tick();
  endtask

  task automatic test_back_to_back();
    hv = 1'b1; ha = 8'h10; hb = 8'h20; hcin = 1'b0; tick();
    hv = 1'b1; ha = 8'h7F; hb = 8'h01; hcin = 1'b0; tick();
    hv = 1'b1; ha = 8'hF0; hb = 8'h0F; hcin = 1'b1; tick();
    idle_inputs();
    repeat (HD + 2) tick();
  endtask

  task automatic test_low_mode();
    lv = 1'b1; la = 8'h12; lb = 8'h34; lcin = 1'b0; tick();
    lv = 1'b1; la = 8'hFF; lb = 8'hFF; lcin = 1'b1; tick();
    idle_inputs();
    repeat (3) tick();
  endtask

  task automatic test_backpressure();
    logic [W:0] hsnap, lsnap;
    for (int i = 0; i < HD; i++) begin
      hv = 1'b1; ha = W'($urandom); hb = W'($urandom); hcin = 1'($urandom);
      lv = 1'b1; la = W'($urandom); lb = W'($urandom); lcin = 1'($urandom);
      tick();
    end
    hsnap = {hc, hs};
    lsnap = {lc, ls};
    hordy = 1'b0; lordy = 1'b0;
    for (int j = 0; j < 3; j++) begin
      ha = W'($urandom); hb = W'($urandom); la = W'($urandom); lb = W'($urandom);
      tick();
      checks++;
      if ({hc, hs, lc, ls} !== {hsnap, lsnap}) begin
        errors++; $display("FAIL stall_hold[%0d] got hi=%h lo=%h expected hi=%h lo=%h",
                           j, {hc, hs}, {lc, ls}, hsnap, lsnap);
      end
    end
    idle_inputs();
    repeat (HD + 2) tick();
  endtask

`ifdef ADDER_OVF_EN
  task automatic test_ovf();
    hv = 1'b1; ha = 8'h7F; hb = 8'h01; hcin = 1'b0;
    lv = 1'b1; la = 8'h7F; lb = 8'h01; lcin = 1'b0; tick();
    hv = 1'b1; ha = 8'h80; hb = 8'hFF; hcin = 1'b0;
    lv = 1'b1; la = 8'h80; lb = 8'hFF; lcin = 1'b0; tick();
    hv = 1'b1; ha = 8'h01; hb = 8'h01; hcin = 1'b0;
    lv = 1'b1; la = 8'h01; lb = 8'h01; lcin = 1'b0; tick();
    idle_inputs();
    repeat (HD + 2) tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      hv = 1'($urandom_range(99) < 70); ha = W'($urandom); hb = W'($urandom); hcin = 1'($urandom);
      hordy = 1'($urandom_range(99) < 65);
      lv = 1'($urandom_range(99) < 70); la = W'($urandom); lb = W'($urandom); lcin = 1'($urandom);
      lordy = 1'($urandom_range(99) < 65);
      tick();
    end
    idle_inputs();
    repeat (HD + 2) tick();
  endtask

  task automatic test_reset_midflight();
    for (int i = 0; i < HD; i++) begin
      hv = 1'b1; ha = W'($urandom); hb = W'($urandom); hcin = 1'($urandom);
      lv = 1'b1; la = W'($urandom); lb = W'($urandom); lcin = 1'($urandom);
      tick();
    end
    idle_inputs();
    #2;
    RST = 1'b0;
    #1;
    check_reset_outputs(1);
    clear_models();
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    repeat (HD + 3) tick();
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_back_to_back();
    test_low_mode();
    test_backpressure();
`ifdef ADDER_OVF_EN
    test_ovf();
`endif
    test_random();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adder_nbits_pipeline_sel.md
# adder_nbits_pipeline_sel

Parametrised N-bit adder with a valid/ready stream interface and a frequency-driven choice of architecture. Below the high-speed threshold it is a single registered adder; above it, a carry-segmented pipeline with configurable depth. It replaces the fixed 4-bit combined/pipeline adder pair as the arithmetic leaf used by datapath blocks on both the 200 MHz and 50 MHz clocks.

## Interface
- WIDTH, 16, operand/sum width in bits; must be a multiple of STAGES
- STAGES, 4, number of pipeline segments in high-speed mode; 1..WIDTH
- CLOCK_FREQUENCY, 100, clock frequency in MHz; compared against HIGH_SPEED_MHZ
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-low reset
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands this cycle
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- cin  in  1  carry in
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- sum  out  WIDTH  a+b+cin, low WIDTH bits
- c  out  1  carry out
- ovf  out  1  signed overflow (only with ADDER_OVF_EN; otherwise absent)

## Operation
- Mode: HIGH_MODE = (CLOCK_FREQUENCY > HIGH_SPEED_MHZ). Resolved at elaboration.
- Low mode: one register stage; sum/c = a+b+cin registered on accept. Effective depth D=1.
- High mode: SEG = WIDTH/STAGES. Stage k (k=0 LSB) adds segment k of a, b plus the carry registered by stage k-1 (stage 0 uses cin). Upper operand segments are delayed through skew registers; completed lower sum segments are delayed to align at the output. D=STAGES.
- Transfer on input: in_valid & in_ready. Transfer on output: out_valid & out_ready.
- Global enable en = ~out_valid | out_ready. in_ready = en. All data and valid registers advance only when en=1.
- Valid bit per stage; an unaccepted input cycle inserts a bubble (valid 0). Bubbles are not collapsed while stalled.
- Data registers of invalid stages hold don't-care values; outputs are qualified by out_valid only.
- Arithmetic is unsigned modulo 2^WIDTH; c is the carry out of bit WIDTH-1.

## Timing
- Reset (RST=0, async): all valid bits 0, sum=0, c=0, ovf=0, out_valid=0. in_ready=1 from the first cycle after release.
- Latency: an operand accepted at edge n appears with out_valid=1 after edge n+D-1 (D cycles later at the output register), given out_ready=1 throughout.
- Throughput: one result per cycle with no stall.
- Stall: out_valid=1 & out_ready=0 freezes every stage; sum/c/ovf held stable; in_ready=0 in the same cycle (combinational from out_ready).
- Simultaneous output pop and input push in the same cycle: both occur; no bubble.
- Reset mid-operation discards all in-flight results; no partial output.
- out_ready is ignored while out_valid=0.

## Configuration
- ADDER_OVF_EN defined: port ovf present; ovf = (a[MSB]==b[MSB]) & (sum[MSB]!=a[MSB]), pipelined alongside sum (MSB sign bits carried through skew registers).
- ADDER_OVF_EN undefined: no ovf port, no associated registers.

## Structure
- Package adder_pkg: localparam HIGH_SPEED_MHZ = 150; function is_high_mode(freq) returning the mode bit.
- Sub-module adder_seg_stage: one SEG-bit registered segment adder with carry in/out and enable, instantiated STAGES times in a generate loop. Low mode uses a single instance with SEG=WIDTH.
- Top level holds the valid chain, skew/align registers and handshake logic.

## Test plan
- WIDTH=8, STAGES=4, CLOCK_FREQUENCY=200: a=0xFF, b=0x01, cin=0 -> after 4 cycles sum=0x00, c=1, out_valid=1 for one cycle.
- Same configuration, back-to-back inputs 0x10+0x20, 0x7F+0x01, 0xF0+0x0F+cin=1 -> sums 0x30/c0, 0x80/c0, 0x00/c1 on three consecutive cycles.
- CLOCK_FREQUENCY=50: a=0x12, b=0x34 -> sum=0x46 one cycle after accept; in_ready stays 1.
- Backpressure: hold out_ready=0 for 3 cycles with the pipeline full -> in_ready=0, sum/c stable; release -> results drain in order, none lost or duplicated.
- ADDER_OVF_EN, WIDTH=8: 0x7F+0x01 -> ovf=1; 0x80+0xFF -> ovf=1, c=1; 0x01+0x01 -> ovf=0.
- Assert RST low with 3 results in flight -> out_valid=0 immediately; after release, no stale results emerge.
